// File: rtl/fixed_hardshrink_backward.sv
// Hardshrink backward pass: records a pass/kill mask per lane from the forward
// activation tap and applies it, strictly in order, to the upstream gradient.
module fixed_hardshrink_backward #(
    parameter int  DATA_IN_0_PRECISION_0       = 8,
    parameter int  DATA_IN_0_PRECISION_1       = 4,
    parameter int  DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int  DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int  GRAD_PRECISION_0            = 8,
    parameter int  GRAD_PRECISION_1            = 4,
    parameter real LAMBDA                      = 0.5,
    parameter int  FX_LAMBDA = $rtoi(LAMBDA * (2 ** DATA_IN_0_PRECISION_1)),
    parameter int  MASK_DEPTH                  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]    data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                                data_in_0_valid,
    output logic                                data_in_0_ready,
    input  logic [GRAD_PRECISION_0-1:0]         grad_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                                grad_out_0_valid,
    output logic                                grad_out_0_ready,
    output logic [GRAD_PRECISION_0-1:0]         grad_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                                grad_in_0_valid,
    input  logic                                grad_in_0_ready,
    output logic [$clog2(MASK_DEPTH):0]         mask_count
);

    localparam int LANES = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int AW    = $clog2(MASK_DEPTH);
    localparam int CW    = AW + 1;
    localparam int XW    = DATA_IN_0_PRECISION_0 + 1;
    localparam logic [CW-1:0] FULL = CW'(MASK_DEPTH);

    // Configuration sanity, checked at elaboration only.
    if (MASK_DEPTH < 2 || (MASK_DEPTH & (MASK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("MASK_DEPTH must be a power of two >= 2");
    end
    if (FX_LAMBDA < 0) begin : g_bad_lambda
        $error("FX_LAMBDA must be non-negative");
    end
    if (GRAD_PRECISION_1 > GRAD_PRECISION_0) begin : g_bad_grad_frac
        $error("GRAD_PRECISION_1 exceeds GRAD_PRECISION_0");
    end

    // One extra bit so that -FX_LAMBDA is representable for any word width.
    logic signed [XW-1:0] w_lam;
    logic signed [XW-1:0] w_nlam;
    assign w_lam  = XW'(FX_LAMBDA);
    assign w_nlam = -w_lam;

    logic [LANES-1:0]    w_mask_wr;
    logic [LANES-1:0]    w_mask_rd;
    logic                w_push;
    logic                w_pop;

    logic [LANES-1:0]    r_mem [MASK_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_valid;
    logic [GRAD_PRECISION_0-1:0] r_grad [LANES];

    // Per-lane mask: pass when |x| strictly exceeds the threshold.
    always_comb begin
        w_mask_wr = '0;
        for (int i = 0; i < LANES; i++) begin
            logic signed [XW-1:0] xe;
            xe = $signed({data_in_0[i][DATA_IN_0_PRECISION_0-1], data_in_0[i]});
            w_mask_wr[i] = (xe > w_lam) || (xe < w_nlam);
        end
    end

    assign data_in_0_ready  = (r_count != FULL);
    assign grad_out_0_ready = (r_count != '0) && (!r_valid || grad_in_0_ready);
    assign w_push           = data_in_0_valid && data_in_0_ready;
    assign w_pop            = grad_out_0_valid && grad_out_0_ready;
    assign w_mask_rd        = r_mem[r_rd_ptr];

    // Mask storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_mask_wr;
        end
    end

    // FIFO pointers and occupancy; count alone distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: load gated gradient on pop, drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_grad[i] <= '0;
            end
        end else if (w_pop) begin
            r_valid <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                r_grad[i] <= w_mask_rd[i] ? grad_out_0[i] : '0;
            end
        end else if (r_valid && grad_in_0_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign grad_in_0       = r_grad;
    assign grad_in_0_valid = r_valid;
    assign mask_count      = r_count;

endmodule

// File: tb/tb_fixed_hardshrink_backward.sv
// Self-checking bench: table-driven vectors plus directed sequences, with a
// handshake-driven scoreboard of expected output beats.
module tb_fixed_hardshrink_backward;

    localparam int FXL   = 8;
    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] data_in_0 [1];
    logic       data_in_0_valid;
    logic       data_in_0_ready;
    logic [7:0] grad_out_0 [1];
    logic       grad_out_0_valid;
    logic       grad_out_0_ready;
    logic [7:0] grad_in_0 [1];
    logic       grad_in_0_valid;
    logic       grad_in_0_ready;
    logic [4:0] mask_count;

    fixed_hardshrink_backward dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .grad_out_0       (grad_out_0),
        .grad_out_0_valid (grad_out_0_valid),
        .grad_out_0_ready (grad_out_0_ready),
        .grad_in_0        (grad_in_0),
        .grad_in_0_valid  (grad_in_0_valid),
        .grad_in_0_ready  (grad_in_0_ready),
        .mask_count       (mask_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] g;
        logic [7:0] e;
    } vec_t;

    vec_t       tbl [8];
    bit         mq [$];    // stored masks, model of the FIFO
    logic [7:0] eq [$];    // expected output beats (at most one pending)
    logic [7:0] tq [$];    // table expectations for the current table run
    int         checks;
    int         errors;
    bit         fwd_acc;

    function automatic bit fmask(input logic [7:0] x);
        int xs;
        xs = int'($signed(x));
        return (xs > FXL) || (xs < -FXL);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check and update the model
    // just after, then let the rising edge commit.
    task automatic cycle(input logic fv, input logic [7:0] fx, input logic gv,
                         input logic [7:0] g, input logic rdy);
        @(negedge clk);
        data_in_0_valid  = fv;
        data_in_0[0]     = fx;
        grad_out_0_valid = gv;
        grad_out_0[0]    = g;
        grad_in_0_ready  = rdy;
        #1;
        check("data_in_0_ready", 32'(data_in_0_ready), 32'(mq.size() != DEPTH));
        check("grad_out_0_ready", 32'(grad_out_0_ready),
              32'((mq.size() != 0) && (eq.size() == 0 || rdy)));
        check("grad_in_0_valid", 32'(grad_in_0_valid), 32'(eq.size() != 0));
        check("mask_count", 32'(mask_count), 32'(mq.size()));
        if (grad_in_0_valid && eq.size() != 0) begin
            check("grad_in_0", 32'(grad_in_0[0]), 32'(eq[0]));
        end
        if (grad_in_0_valid && rdy && eq.size() != 0) begin
            void'(eq.pop_front());
            if (tq.size() != 0) begin
                check("table_grad", 32'(grad_in_0[0]), 32'(tq.pop_front()));
            end
        end
        if (gv && grad_out_0_ready && mq.size() != 0) begin
            eq.push_back(mq.pop_front() ? g : 8'h00);
        end
        fwd_acc = fv && data_in_0_ready;
        if (fwd_acc) begin
            mq.push_back(fmask(fx));
        end
    endtask

    task automatic run_table(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, tbl[i].x, 1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < n; i++) begin
            tq.push_back(tbl[i].e);
            cycle(1'b0, 8'h00, 1'b1, tbl[i].g, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("table_drained", 32'(tq.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{x: 8'h09, g: 8'h15, e: 8'h15};
        tbl[1] = '{x: 8'h08, g: 8'h15, e: 8'h00};
        tbl[2] = '{x: 8'hF8, g: 8'h15, e: 8'h00};
        tbl[3] = '{x: 8'hF7, g: 8'h15, e: 8'h15};
        tbl[4] = '{x: 8'h00, g: 8'h15, e: 8'h00};
        tbl[5] = '{x: 8'h7F, g: 8'hA3, e: 8'hA3};
        tbl[6] = '{x: 8'h80, g: 8'h5C, e: 8'h5C};
        tbl[7] = '{x: 8'h07, g: 8'hFF, e: 8'h00};

        rst              = 1'b1;
        data_in_0_valid  = 1'b0;
        data_in_0[0]     = 8'h00;
        grad_out_0_valid = 1'b0;
        grad_out_0[0]    = 8'h00;
        grad_in_0_ready  = 1'b1;
        #12;
        check("rst_count", 32'(mask_count), 32'd0);
        check("rst_valid", 32'(grad_in_0_valid), 32'd0);
        check("rst_grad", 32'(grad_in_0[0]), 32'd0);
        check("rst_in_ready", 32'(data_in_0_ready), 32'd1);
        check("rst_g_ready", 32'(grad_out_0_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic masking, thresholds and extremes.
        run_table(8);

        // Fill to capacity, stall the 17th beat, free one slot.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(i * 17), 1'b0, 8'h00, 1'b1);
        end
        cycle(1'b1, 8'hC0, 1'b0, 8'h00, 1'b1);
        check("full_stall", 32'(fwd_acc), 32'd0);
        cycle(1'b1, 8'hC0, 1'b1, 8'h33, 1'b1);
        check("full_stall_pop", 32'(fwd_acc), 32'd0);
        cycle(1'b1, 8'hC0, 1'b0, 8'h00, 1'b1);
        check("full_accept", 32'(fwd_acc), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("full_count", 32'(mask_count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 8'(8'h40 + i), 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // No bypass: gradient waits while its mask is pushed.
        cycle(1'b1, 8'h20, 1'b1, 8'h6B, 1'b1);
        check("nobypass_ready", 32'(grad_out_0_ready), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 8'h6B, 1'b1);
        check("nobypass_ready_next", 32'(grad_out_0_ready), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("nobypass_valid", 32'(grad_in_0_valid), 32'd1);

        // Output backpressure: held beat stays stable, no pops.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'hE0, 1'b0, 8'h00, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 8'(8'h22 + i), 1'b0);
        end
        check("bp_count", 32'(mask_count), 32'd2);
        cycle(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 8'h66, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Steady push and pop one short of full; pointers wrap.
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        end
        check("steady_count", 32'(mask_count), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Mid-stream reset with stored masks and a held output beat.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'h30, 1'b0, 8'h00, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("pre_rst_count", 32'(mask_count), 32'd7);
        data_in_0_valid  = 1'b0;
        grad_out_0_valid = 1'b0;
        rst              = 1'b1;
        #1;
        check("mid_rst_count", 32'(mask_count), 32'd0);
        check("mid_rst_valid", 32'(grad_in_0_valid), 32'd0);
        check("mid_rst_in_ready", 32'(data_in_0_ready), 32'd1);
        check("mid_rst_g_ready", 32'(grad_out_0_ready), 32'd0);
        mq.delete();
        eq.delete();
        tq.delete();
        @(negedge clk);
        rst = 1'b0;

        run_table(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
